// File: rtl/sprite_draw_engine_pkg.sv
// Shared definitions for the sprite draw engine.
// Holds the sprite selector codes, the screen geometry, the 3-bit VGA colour
// constants (including the transparent code), the FSM state type and the
// function that defines the sprite bitmaps held in the ROM.
package sprite_draw_engine_pkg;

  typedef enum logic [1:0] {
    SPR_GOLD    = 2'd0,
    SPR_STONE   = 2'd1,
    SPR_DIAMOND = 2'd2,
    SPR_HOOK    = 2'd3
  } spr_sel_e;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_BLUE   = 3'b001;
  localparam logic [2:0] COL_GREEN  = 3'b010;
  localparam logic [2:0] COL_CYAN   = 3'b011;
  localparam logic [2:0] COL_RED    = 3'b100;
  localparam logic [2:0] TRANSP     = 3'b101;
  localparam logic [2:0] COL_YELLOW = 3'b110;
  localparam logic [2:0] COL_WHITE  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAW  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Sprite bitmaps, expressed as a function of (sprite, row, col) so the ROM
  // contents scale with the sprite size:
  //   gold    - solid yellow
  //   stone   - white with rounded (transparent) corners
  //   diamond - cyan/blue checkerboard
  //   hook    - red vertical bar at the centre column plus the bottom row
  function automatic logic [2:0] sprite_pixel(input logic [1:0]  sel,
                                              input int unsigned row,
                                              input int unsigned col,
                                              input int unsigned w,
                                              input int unsigned h);
    logic [2:0] c;
    c = TRANSP;
    case (spr_sel_e'(sel))
      SPR_GOLD:    c = COL_YELLOW;
      SPR_STONE: begin
        if (((row == 0) || (row == h - 1)) && ((col < 2) || (col >= w - 2)))
          c = TRANSP;
        else if (((row == 1) || (row == h - 2)) && ((col == 0) || (col == w - 1)))
          c = TRANSP;
        else
          c = COL_WHITE;
      end
      SPR_DIAMOND: c = (((row + col) & 1) == 0) ? COL_CYAN : COL_BLUE;
      SPR_HOOK:    c = ((col == w / 2) || (row == h - 1)) ? COL_RED : TRANSP;
      default:     c = TRANSP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sprite_draw_engine_if.sv
// Draw handshake and VGA pixel-write bundle between the view controller
// (master) and a sprite draw engine (slave).
//   enable_draw          request level, held until draw_done
//   sprite_sel/obj_x/y   sprite and top-left position, latched at start
//   vga_x/y/colour/plot  pixel-write port, one pixel per cycle
//   busy                 engine drawing or draining
//   draw_done            completion level
interface sprite_draw_engine_if;
  logic       enable_draw;
  logic [1:0] sprite_sel;
  logic [7:0] obj_x;
  logic [6:0] obj_y;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       draw_done;

  modport master (
    output enable_draw, sprite_sel, obj_x, obj_y,
    input  vga_x, vga_y, vga_colour, vga_plot, busy, draw_done
  );

  modport slave (
    input  enable_draw, sprite_sel, obj_x, obj_y,
    output vga_x, vga_y, vga_colour, vga_plot, busy, draw_done
  );
endinterface

// File: rtl/sprite_draw_engine_rom.sv
// sprite_rom: synchronous single-port ROM holding four SPR_W x SPR_H sprites
// of 3-bit colour codes, one-cycle read latency.
//   clk     system clock
//   addr_i  {sprite, row, col}
//   data_o  colour code, valid the cycle after addr_i is presented
// Contents come from the sprite_pixel table in the package, so the array is a
// constant decode that synthesis maps to ROM.
module sprite_rom
  import sprite_draw_engine_pkg::*;
#(
  parameter  int unsigned SPR_W = 8,
  parameter  int unsigned SPR_H = 8,
  localparam int unsigned CW    = $clog2(SPR_W),
  localparam int unsigned RW    = $clog2(SPR_H),
  localparam int unsigned AW    = 2 + RW + CW
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  output logic [2:0]    data_o
);

  always_ff @(posedge clk) begin
    data_o <= sprite_pixel(addr_i[AW-1 -: 2],
                           32'(addr_i[CW+RW-1:CW]),
                           32'(addr_i[CW-1:0]),
                           SPR_W, SPR_H);
  end

endmodule

// File: rtl/sprite_draw_engine.sv
// sprite_draw_engine: responder side of the controller draw handshake.
// On a held enable_draw it rasterises one sprite from ROM into the VGA
// pixel-write port in raster order, skipping transparent and off-screen
// pixels, then holds draw_done until the request is dropped.
//   clk, resetn  clock and asynchronous active-low reset
//   bus          sprite_draw_engine_if.slave (request + pixel port)
// Pipeline: address cycle -> ROM/coordinate stage -> output registers, so
// pixel k appears on vga_* two cycles after it is addressed.
module sprite_draw_engine
  import sprite_draw_engine_pkg::*;
#(
  parameter int unsigned SPR_W    = 8,
  parameter int unsigned SPR_H    = 8,
  parameter int unsigned SCREEN_W = sprite_draw_engine_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H = sprite_draw_engine_pkg::SCREEN_H,
  parameter logic [2:0]  TRANSP   = sprite_draw_engine_pkg::TRANSP
) (
  input  logic                 clk,
  input  logic                 resetn,
  sprite_draw_engine_if.slave  bus
);

  localparam int unsigned CW = $clog2(SPR_W);
  localparam int unsigned RW = $clog2(SPR_H);
  localparam int unsigned AW = 2 + RW + CW;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [1:0]      sel_q, sel_d;
  logic [7:0]      ox_q, ox_d;
  logic [6:0]      oy_q, oy_d;
  logic            flush_q, flush_d;

  logic            s1_act_q, s1_act_d;
  logic            s1_vis_q, s1_vis_d;
  logic [7:0]      s1_x_q, s1_x_d;
  logic [6:0]      s1_y_q, s1_y_d;

  logic            plot_q, plot_d;
  logic [7:0]      vx_q, vx_d;
  logic [6:0]      vy_q, vy_d;
  logic [2:0]      vc_q, vc_d;

  logic [AW-1:0]   rom_addr;
  logic [2:0]      rom_data;
  logic [8:0]      scr_x;
  logic [7:0]      scr_y;
  logic            on_screen;
  logic            last_pix;
  logic            in_flight;
  logic            abort;

  // Power-of-two sprite sizes make the ROM address a plain concatenation.
  assign rom_addr  = {sel_q, row_q, col_q};

  sprite_rom #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_rom (
    .clk    (clk),
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  // Wide enough that a sprite hanging off the right/bottom edge cannot wrap
  // back on screen.
  assign scr_x     = {1'b0, ox_q} + 9'(col_q);
  assign scr_y     = {1'b0, oy_q} + 8'(row_q);
  assign on_screen = (32'(scr_x) < SCREEN_W) && (32'(scr_y) < SCREEN_H);
  assign last_pix  = (&col_q) && (&row_q);
  assign in_flight = (state_q == S_DRAW) || (state_q == S_FLUSH);
  assign abort     = in_flight && !bus.enable_draw;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    sel_d   = sel_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    flush_d = flush_q;
    case (state_q)
      S_IDLE: begin
        if (bus.enable_draw) begin
          state_d = S_DRAW;
          sel_d   = bus.sprite_sel;
          ox_d    = bus.obj_x;
          oy_d    = bus.obj_y;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_DRAW: begin
        if (!bus.enable_draw) begin
          state_d = S_IDLE;
        end else begin
          col_d = col_q + 1'b1;
          if (&col_q) row_d = row_q + 1'b1;
          if (last_pix) begin
            state_d = S_FLUSH;
            flush_d = 1'b0;
          end
        end
      end
      S_FLUSH: begin
        if (!bus.enable_draw) state_d = S_IDLE;
        else if (flush_q)     state_d = S_DONE;
        else                  flush_d = 1'b1;
      end
      S_DONE: begin
        if (!bus.enable_draw) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s1_act_d = (state_q == S_DRAW) && bus.enable_draw;
    s1_vis_d = s1_act_d && on_screen;
    s1_x_d   = scr_x[7:0];
    s1_y_d   = scr_y[6:0];
    // An abort kills the pixel leaving stage 1 as well as the one in stage 2.
    plot_d   = s1_vis_q && (rom_data != TRANSP) && !abort;
    vx_d     = s1_act_q ? s1_x_q   : vx_q;
    vy_d     = s1_act_q ? s1_y_q   : vy_q;
    vc_d     = s1_act_q ? rom_data : vc_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      sel_q    <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      flush_q  <= 1'b0;
      s1_act_q <= 1'b0;
      s1_vis_q <= 1'b0;
      s1_x_q   <= '0;
      s1_y_q   <= '0;
      plot_q   <= 1'b0;
      vx_q     <= '0;
      vy_q     <= '0;
      vc_q     <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      sel_q    <= sel_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      flush_q  <= flush_d;
      s1_act_q <= s1_act_d;
      s1_vis_q <= s1_vis_d;
      s1_x_q   <= s1_x_d;
      s1_y_q   <= s1_y_d;
      plot_q   <= plot_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      vc_q     <= vc_d;
    end
  end

  assign bus.vga_x      = vx_q;
  assign bus.vga_y      = vy_q;
  assign bus.vga_colour = vc_q;
  // Gated so the strobe drops in the very cycle the request is withdrawn.
  assign bus.vga_plot   = plot_q && !abort;
  assign bus.busy       = in_flight;
  assign bus.draw_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_sprite_draw_engine.sv
module tb_sprite_draw_engine;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sprite_draw_engine_if bus();

  sprite_draw_engine #(
    .SPR_W    (8),
    .SPR_H    (8),
    .SCREEN_W (160),
    .SCREEN_H (120),
    .TRANSP   (3'b101)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [1:0] sel;
    logic [7:0] ox;
    logic [6:0] oy;
    int         abort_n;    // period in which enable drops early, 0 = none
    int         exp_plots;
    int         exp_first;  // period of first plot
    int         exp_done;   // period draw_done rises, 0 = never
  } vec_t;

  vec_t vecs[9];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Independent 8x8 bitmap reference.
  function automatic int model_colour(input int sel, input int r, input int c);
    case (sel)
      0: return 6;
      1: begin
        if ((r == 0 || r == 7) && (c <= 1 || c >= 6)) return 5;
        if ((r == 1 || r == 6) && (c == 0 || c == 7)) return 5;
        return 7;
      end
      2: return (((r + c) % 2) == 0) ? 3 : 1;
      default: return (c == 4 || r == 7) ? 4 : 5;
    endcase
  endfunction

  // Called mid-cycle with the DUT idle; the next posedge is E0 (period 1
  // is the cycle after E0).
  task automatic run_vec(input vec_t v, input int idx);
    int plots, first, pix_err, busy_err, done_err, overlap, last_n;
    int k, r, c, ex_x, ex_y, ex_c, busy_end;
    logic ex_plot, ex_busy, ex_done;
    plots = 0; first = -1; pix_err = 0; busy_err = 0; done_err = 0; overlap = 0;
    bus.sprite_sel  = v.sel;
    bus.obj_x       = v.ox;
    bus.obj_y       = v.oy;
    bus.enable_draw = 1'b1;
    last_n   = (v.abort_n != 0) ? v.abort_n + 2 : 73;
    busy_end = (v.abort_n != 0) ? v.abort_n : 66;
    for (int n = 1; n <= last_n; n++) begin
      @(posedge clk);
      if ((v.abort_n != 0 && n == v.abort_n) || (v.abort_n == 0 && n == 72))
        #1 bus.enable_draw = 1'b0;
      @(negedge clk);
      k = n - 3; r = k / 8; c = k % 8;
      ex_plot = 1'b0; ex_x = 0; ex_y = 0; ex_c = 0;
      if (k >= 0 && k < 64 && (v.abort_n == 0 || n < v.abort_n)) begin
        ex_x = int'(v.ox) + c;
        ex_y = int'(v.oy) + r;
        ex_c = model_colour(int'(v.sel), r, c);
        ex_plot = (ex_x < 160) && (ex_y < 120) && (ex_c != 5);
      end
      if (bus.vga_plot === 1'b1) begin
        plots++;
        if (first < 0) first = n;
      end
      if (bus.vga_plot !== ex_plot) pix_err++;
      else if (ex_plot && (int'(bus.vga_x) != ex_x || int'(bus.vga_y) != ex_y ||
                           int'(bus.vga_colour) != ex_c)) pix_err++;
      ex_busy = (n <= busy_end);
      if (bus.busy !== ex_busy) busy_err++;
      ex_done = (v.exp_done != 0) && (n >= v.exp_done) && (n <= 72);
      if (bus.draw_done !== ex_done) done_err++;
      if (bus.vga_plot === 1'b1 && bus.draw_done === 1'b1) overlap++;
    end
    check($sformatf("v%0d plot_count", idx), plots, v.exp_plots);
    check($sformatf("v%0d first_plot_period", idx), first, v.exp_first);
    check($sformatf("v%0d pixel_errors", idx), pix_err, 0);
    check($sformatf("v%0d busy_errors", idx), busy_err, 0);
    check($sformatf("v%0d done_errors", idx), done_err, 0);
    check($sformatf("v%0d plot_done_overlap", idx), overlap, 0);
  endtask

  initial begin
    int err;
    vecs[0] = '{2'd0, 8'd10,  7'd20,  0,  64, 3, 67};  // opaque gold
    vecs[1] = '{2'd1, 8'd30,  7'd40,  0,  52, 5, 67};  // stone, 12 transparent
    vecs[2] = '{2'd2, 8'd156, 7'd116, 0,  16, 3, 67};  // clipped diamond
    vecs[3] = '{2'd3, 8'd0,   7'd0,   0,  15, 7, 67};  // hook
    vecs[4] = '{2'd0, 8'd10,  7'd20,  10, 7,  3, 0};   // abort in DRAW
    vecs[5] = '{2'd0, 8'd50,  7'd60,  0,  64, 3, 67};  // redraw after abort
    vecs[6] = '{2'd0, 8'd0,   7'd0,   65, 62, 3, 0};   // abort in FLUSH
    vecs[7] = '{2'd3, 8'd0,   7'd0,   0,  15, 7, 67};  // back-to-back pair
    vecs[8] = '{2'd0, 8'd50,  7'd60,  0,  64, 3, 67};

    bus.enable_draw = 1'b0;
    bus.sprite_sel  = '0;
    bus.obj_x       = '0;
    bus.obj_y       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", int'({bus.vga_x, bus.vga_y, bus.vga_colour,
                                 bus.vga_plot, bus.busy, bus.draw_done}), 0);
    resetn = 1'b1;

    // Reset in the middle of a draw: outputs clear without waiting for a clock.
    @(negedge clk);
    bus.sprite_sel = 2'd0; bus.obj_x = 8'd10; bus.obj_y = 7'd20;
    bus.enable_draw = 1'b1;
    repeat (30) @(posedge clk);
    #1 resetn = 1'b0;
    bus.enable_draw = 1'b0;
    #1 check("async_reset_outputs", int'({bus.vga_x, bus.vga_y, bus.vga_colour,
                                          bus.vga_plot, bus.busy, bus.draw_done}), 0);
    @(negedge clk);
    resetn = 1'b1;
    err = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.vga_plot !== 1'b0 || bus.busy !== 1'b0 || bus.draw_done !== 1'b0) err++;
    end
    check("post_reset_idle", err, 0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
